// File: rtl/lfsr_checker.sv
// lfsr_checker -- locks onto a 32-bit LFSR stream (x^32+x^22+x^2+x+1,
// shift left, feedback into the LSB) and counts errors while locked.
//
// Parameters
//   N         word width
//   LOCK_CNT  consecutive predicted words needed to declare lock
//   LOSS_CNT  consecutive mispredicted words while locked that drop lock
// Ports
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset
//   VALID     DIN carries one generator step this cycle
//   DIN       observed generator word
//   CLR       synchronous clear of ERR_CNT and ZERO_ERR
//   LOCKED    checker is synchronised (state == LOCK)
//   ERR       one-cycle pulse for a mismatch while locked
//   ERR_CNT   saturating count of locked mismatches
//   ZERO_ERR  sticky all-zero word flag
// Build option
//   LFSR_CHK_ZERO_DET_EN  enables all-zero word detection; when undefined
//                         ZERO_ERR is tied low and zero is ordinary data.
module lfsr_checker #(
  parameter int N        = 32,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         VALID,
  input  logic [N-1:0] DIN,
  input  logic         CLR,
  output logic         LOCKED,
  output logic         ERR,
  output logic [15:0]  ERR_CNT,
  output logic         ZERO_ERR
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {S_HUNT, S_TRACK, S_LOCK} state_t;

  function automatic logic [N-1:0] f_next(input logic [N-1:0] x);
    return {x[N-2:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_pred;
  logic [MW-1:0]  r_match;
  logic [SW-1:0]  r_miss;
  logic           r_err;
  logic [15:0]    r_err_cnt;

  logic           w_eq;
  logic           w_zero;
  logic           w_bad;
  logic           w_lock_miss;
  logic           w_lock_hit;

  assign w_eq = (DIN == r_pred);

`ifdef LFSR_CHK_ZERO_DET_EN
  assign w_zero = VALID && (DIN == '0);
`else
  assign w_zero = 1'b0;
`endif

  // A zero word counts as a miss in LOCK even if the prediction were zero.
  assign w_bad       = !w_eq || w_zero;
  assign w_lock_miss = VALID && (r_state == S_LOCK) && w_bad;
  assign w_lock_hit  = w_eq && (r_match == MW'(LOCK_CNT - 1));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_HUNT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (VALID) begin
      unique case (r_state)
        S_HUNT:  w_state_nxt = S_TRACK;
        S_TRACK: if (w_lock_hit) w_state_nxt = S_LOCK;
        S_LOCK:  if (w_bad && (r_miss == SW'(LOSS_CNT - 1))) w_state_nxt = S_HUNT;
        default: w_state_nxt = S_HUNT;
      endcase
      if (w_zero) w_state_nxt = S_HUNT;
    end
  end

  // Output logic: all outputs come straight from registers
  always_comb begin
    LOCKED  = (r_state == S_LOCK);
    ERR     = r_err;
    ERR_CNT = r_err_cnt;
  end

  // Predictor and run counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pred  <= '0;
      r_match <= '0;
      r_miss  <= '0;
    end else if (VALID) begin
      unique case (r_state)
        S_HUNT: begin
          r_pred  <= f_next(DIN);
          r_match <= '0;
        end
        S_TRACK: begin
          // Track mode follows the data: every word reseeds the predictor.
          r_pred <= f_next(DIN);
          if (w_eq) begin
            r_match <= r_match + MW'(1);
            if (w_lock_hit) r_miss <= '0;
          end else begin
            r_match <= '0;
          end
        end
        S_LOCK: begin
          // Locked predictor free-runs so corrupted words cannot steer it.
          r_pred <= f_next(r_pred);
          if (w_bad) r_miss <= r_miss + SW'(1);
          else       r_miss <= '0;
        end
        default: ;
      endcase
    end
  end

  // Error pulse and saturating counter; CLR wins over an increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_lock_miss;
      if (CLR)                                  r_err_cnt <= '0;
      else if (w_lock_miss && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

`ifdef LFSR_CHK_ZERO_DET_EN
  logic r_zero_err;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         r_zero_err <= 1'b0;
    else if (CLR)    r_zero_err <= 1'b0;
    else if (w_zero) r_zero_err <= 1'b1;
  end
  assign ZERO_ERR = r_zero_err;
`else
  assign ZERO_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;
  localparam int N        = 32;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          VALID;
  logic [N-1:0]  DIN;
  logic          CLR;
  logic          LOCKED;
  logic          ERR;
  logic [15:0]   ERR_CNT;
  logic          ZERO_ERR;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: expressed as "run length of chained words" while
  // unlocked and "expected word + miss streak" while locked.
  logic        m_locked, m_err, m_zero;
  logic [15:0] m_cnt;
  logic [31:0] m_prev, m_exp;
  int          m_run, m_miss;
  logic [31:0] g;  // next correct generator word

  lfsr_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .CLK(CLK), .RST(RST), .VALID(VALID), .DIN(DIN), .CLR(CLR),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_CNT(ERR_CNT), .ZERO_ERR(ZERO_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_next(input logic [31:0] x);
    logic fb;
    fb = ^(x & 32'h80200003);
    return (x << 1) | {31'b0, fb};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_zero = 0; m_cnt = 0;
    m_prev = 0; m_exp = 0; m_run = 0; m_miss = 0;
  endtask

  task automatic model_update(input logic v, input logic [31:0] d, input logic c);
    logic miss;
    m_err = 0;
    miss  = 0;
    if (v) begin
`ifdef LFSR_CHK_ZERO_DET_EN
      if (d == 0) begin
        m_zero = 1;
        if (m_locked) miss = 1;
        m_locked = 0;
        m_run    = 0;
      end else
`endif
      if (m_locked) begin
        if (d != m_exp) begin
          miss = 1;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_locked = 0;
            m_run    = 0;
          end
        end else m_miss = 0;
        m_exp = ref_next(m_exp);
      end else begin
        if (m_run == 0 || d != ref_next(m_prev)) m_run = 1;
        else                                     m_run++;
        m_prev = d;
        if (m_run == LOCK_CNT + 1) begin
          m_locked = 1;
          m_miss   = 0;
          m_exp    = ref_next(d);
        end
      end
    end
    if (miss) begin
      m_err = 1;
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    if (c) begin
      m_cnt  = 0;
      m_zero = 0;
    end
  endtask

  // Drive one cycle (inputs at negedge), update model at posedge, settle.
  task automatic step(input logic v, input logic [31:0] d, input logic c);
    @(negedge CLK);
    VALID = v; DIN = d; CLR = c;
    @(posedge CLK);
    model_update(v, d, c);
    #1;
  endtask

  task automatic good();
    step(1, g, 0);
    g = ref_next(g);
  endtask

  task automatic test_reset();
    RST = 1; VALID = 0; DIN = 0; CLR = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if (LOCKED !== 0 || ERR !== 0 || ERR_CNT !== 0 || ZERO_ERR !== 0)
      $display("FAIL reset: got L=%b E=%b C=%0d Z=%b want 0 0 0 0", LOCKED, ERR, ERR_CNT, ZERO_ERR);
    else n_pass++;
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_lock();
    g = 32'h12345678;
    for (int i = 0; i < 7; i++) begin
      good();
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL lock[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
    n_chk++;
    if (LOCKED !== 1'b1) $display("FAIL lock_final: got L=%b want 1", LOCKED);
    else n_pass++;
  endtask

  task automatic test_single_flip();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        step(1, g ^ 32'h1, 0);
        g = ref_next(g);
      end else good();
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL flip[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
  endtask

  task automatic test_loss_relock();
    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        step(1, g ^ 32'hFFFF0000, 0);
        g = ref_next(g);
      end else good();
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL loss[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
  endtask

  task automatic test_clr();
    // clr alone, bad, good, bad, good, bad+clr, good
    logic [6:0] v_bad = 7'b0010101 << 1;
    for (int i = 0; i < 7; i++) begin
      logic c;
      c = (i == 0) || (i == 5);
      if (i == 0) step(0, 0, 1);
      else begin
        step(1, v_bad[i] ? (g ^ 32'h1) : g, c);
        g = ref_next(g);
      end
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL clr[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
  endtask

  task automatic test_zero_word();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        step(1, 32'h0, 0);
        g = ref_next(g);
      end else good();
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL zero[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    // drop lock, then two chained words leave the checker in TRACK
    for (int i = 0; i < 3; i++) begin
      step(1, ~g, 0);
      g = ref_next(g);
    end
    good();
    good();
    step(0, 0, 0);
    n_chk++;
    if (LOCKED !== m_locked || ERR_CNT !== m_cnt || ERR_CNT == 16'd0)
      $display("FAIL pre_rst: got L=%b C=%0d want %b %0d (nonzero)", LOCKED, ERR_CNT, m_locked, m_cnt);
    else n_pass++;
    @(posedge CLK);
    #3 RST = 1;
    model_reset();
    #1;
    n_chk++;
    if (LOCKED !== 0 || ERR !== 0 || ERR_CNT !== 0 || ZERO_ERR !== 0)
      $display("FAIL async_rst: got L=%b E=%b C=%0d Z=%b want 0 0 0 0", LOCKED, ERR, ERR_CNT, ZERO_ERR);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    VALID = 0; CLR = 0;
    RST = 0;
    // first beat after reset is a HUNT beat: lock after exactly LOCK_CNT+1
    g = $urandom | 32'h1;
    for (int i = 0; i < LOCK_CNT + 2; i++) begin
      good();
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL post_rst[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic        v, c;
      logic [31:0] d;
      int          r;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 19);
      if (r == 2) g = $urandom;
      case (r)
        0:       d = $urandom;
        1:       d = g ^ (32'h1 << $urandom_range(0, 31));
        3:       d = 32'h0;
        default: d = g;
      endcase
      step(v, d, c);
      if (v) g = ref_next(g);
      n_chk++;
      if (LOCKED !== m_locked || ERR !== m_err || ERR_CNT !== m_cnt || ZERO_ERR !== m_zero)
        $display("FAIL rand[%0d]: got L=%b E=%b C=%0d Z=%b want %b %b %0d %b", i,
                 LOCKED, ERR, ERR_CNT, ZERO_ERR, m_locked, m_err, m_cnt, m_zero);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_flip();
    test_loss_relock();
    test_clr();
    test_zero_word();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter N, default 32: LFSR word width.
REQ-002 Parameter LOCK_CNT, default 4: consecutive matching words required to declare lock.
REQ-003 Parameter LOSS_CNT, default 3: consecutive mismatching words while locked that force loss of lock.
REQ-004 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port VALID, input, 1 bit: DIN carries one generator step this cycle.
REQ-007 Port DIN, input, N bits: observed generator output word.
REQ-008 Port CLR, input, 1 bit: synchronous clear of the error counter and sticky flags.
REQ-009 Port LOCKED, output, 1 bit: checker is synchronised to the sequence.
REQ-010 Port ERR, output, 1 bit: one-cycle pulse flagging a mismatch while locked.
REQ-011 Port ERR_CNT, output, 16 bits: saturating count of locked mismatches.
REQ-012 Port ZERO_ERR, output, 1 bit: sticky flag for an all-zero word (see Configuration).

Function
REQ-013 The step function SHALL be next(x) = {x[N-2:0], x[31]^x[21]^x[1]^x[0]}, using polynomial x^32+x^22+x^2+x+1, shift left with feedback into the LSB.
REQ-014 The state machine SHALL have three states: HUNT, TRACK and LOCK. Internal registers are PRED (N bits), MATCH (counts to LOCK_CNT) and MISS (counts to LOSS_CNT).
REQ-015 When VALID=0, no state, counter or register SHALL change, except through CLR.
REQ-016 HUNT, on VALID: PRED <= next(DIN), MATCH <= 0, go to TRACK.
REQ-017 TRACK, on VALID with DIN==PRED: MATCH increments and PRED <= next(DIN). When MATCH reaches LOCK_CNT, go to LOCK and set MISS <= 0.
REQ-018 TRACK, on VALID with DIN!=PRED: MATCH <= 0 and PRED <= next(DIN) (reseed); stay in TRACK; ERR is not asserted.
REQ-019 LOCK, on VALID: PRED <= next(PRED), so it free-runs and does not follow corrupted data.
- Match: MISS <= 0.
- Mismatch: ERR=1 the next cycle, ERR_CNT increments (saturates at 16'hFFFF), MISS increments.
- When MISS reaches LOSS_CNT: go to HUNT and drop LOCKED.
REQ-020 LOCKED, ERR and ERR_CNT SHALL be registered and reflect the VALID beat of the previous cycle (latency 1).
REQ-021 LOCKED=1 exactly when the state is LOCK.
REQ-022 CLR SHALL zero ERR_CNT and ZERO_ERR on the next edge. CLR takes priority over a simultaneous increment, so the result is 0. CLR does not affect state, PRED, MATCH or MISS.
REQ-023 On the beat where lock is declared (TRACK to LOCK), there is no comparison in LOCK. On the beat that causes the LOSS_CNT-th miss, ERR still pulses and ERR_CNT still increments.

Reset
REQ-024 RST=1 SHALL immediately force the following, independent of CLK and also mid-sequence:
- state = HUNT
- PRED, MATCH and MISS = 0
- LOCKED, ERR, ZERO_ERR = 0
- ERR_CNT = 0
REQ-025 The first VALID beat after RST deasserts SHALL be handled as a HUNT beat.

Configuration
REQ-026 The macro LFSR_CHK_ZERO_DET_EN SHALL enable all-zero lock-up detection.
- Defined: VALID with DIN==0, in any state, sets ZERO_ERR (sticky) and forces HUNT on the next edge. In LOCK the beat also counts as a mismatch.
- Undefined: ZERO_ERR is tied to 0, and an all-zero word is treated as ordinary data.

Verification
REQ-027 Reset, then feed VALID words seeded at 32'h12345678, second word 32'h2468ACF1, then successive next() words -> LOCKED rises 1 cycle after the 5th word; ERR stays 0.
REQ-028 While locked, flip DIN bit 0 on one word only -> ERR pulses once; ERR_CNT=1; LOCKED stays 1; following correct words give no ERR.
REQ-029 While locked, drive 3 consecutive wrong words -> ERR_CNT=3 and LOCKED falls after the 3rd. Resuming the correct sequence relocks after 5 words.
REQ-030 Locked with ERR_CNT=2, assert CLR in the same cycle as a mismatching word -> ERR_CNT=0 and ERR pulses.
REQ-031 Assert RST asynchronously mid-TRACK (between clock edges) -> all outputs read 0 immediately, before the next edge.
REQ-032 With LFSR_CHK_ZERO_DET_EN defined, while locked drive DIN=32'h0 -> ZERO_ERR=1, LOCKED=0 the next cycle, ERR_CNT increments. Without the macro, ZERO_ERR stays 0.
